// File: rtl/alu_pkg.sv
// ALU operation encodings shared by the ALU share arbiter and its neighbours.
package alu_pkg;
  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_ADDU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SUBU = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_ADD  = 4'd11;
  localparam logic [3:0] ALU_SUB  = 4'd12;
endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt,
  output logic            gnt_valid
);
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_valid && req[j]) begin
        gnt       = IDW'(j);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters with a single
// registered, requester-tagged response slot and a saturating overflow counter.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2,
  parameter int OFCW = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [4*NREQ-1:0]  req_op,
  input  logic [32*NREQ-1:0] req_rs,
  input  logic [32*NREQ-1:0] req_rt,
  input  logic [5*NREQ-1:0]  req_sa,
  output logic [3:0]         alu_op,
  output logic [31:0]        alu_rs,
  output logic [31:0]        alu_rt,
  output logic [4:0]         alu_sa,
  input  logic [31:0]        alu_rd,
  input  logic               alu_zf,
  input  logic               alu_of,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_rd,
  output logic               rsp_zf,
  output logic               rsp_of,
  output logic [OFCW-1:0]    of_count
);
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic           gnt_valid;
  logic           can_accept;
  logic           accept;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Gated by resetn so no requester sees a handshake while reset is held.
  assign can_accept = resetn & (~rsp_valid | rsp_ready);
  assign accept     = can_accept & gnt_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  // ALU sees the granted request even while stalled; idle drives PASS with zero operands.
  always_comb begin
    alu_op = ALU_PASS;
    alu_rs = '0;
    alu_rt = '0;
    alu_sa = '0;
    if (gnt_valid) begin
      alu_op = req_op[4*int'(gnt) +: 4];
      alu_rs = req_rs[32*int'(gnt) +: 32];
      alu_rt = req_rt[32*int'(gnt) +: 32];
      alu_sa = req_sa[5*int'(gnt) +: 5];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rd    <= '0;
      rsp_zf    <= 1'b0;
      rsp_of    <= 1'b0;
      of_count  <= '0;
    end else begin
      if (accept) begin
        rr_ptr    <= (int'(gnt) == NREQ-1) ? '0 : gnt + 1'b1;
        rsp_valid <= 1'b1;
        rsp_id    <= gnt;
        rsp_rd    <= alu_rd;
        rsp_zf    <= alu_zf;
        rsp_of    <= alu_of;
        if (alu_of && !(&of_count)) of_count <= of_count + 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
  localparam int OFCW = 3;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_rs;
  logic [32*NREQ-1:0] req_rt;
  logic [5*NREQ-1:0]  req_sa;
  logic [3:0]         alu_op;
  logic [31:0]        alu_rs, alu_rt, alu_rd;
  logic [4:0]         alu_sa;
  logic               alu_zf, alu_of;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_rd;
  logic               rsp_zf, rsp_of;
  logic [OFCW-1:0]    of_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .OFCW(OFCW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_sa(req_sa),
    .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_sa(alu_sa),
    .alu_rd(alu_rd), .alu_zf(alu_zf), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rd(rsp_rd), .rsp_zf(rsp_zf), .rsp_of(rsp_of),
    .of_count(of_count)
  );

  // Reduced ALU: the ops this bench issues.
  always_comb begin
    alu_rd = 32'h0;
    alu_of = 1'b0;
    case (alu_op)
      4'd3:  alu_rd = alu_rs + alu_rt;
      4'd6:  alu_rd = alu_rs - alu_rt;
      4'd11: begin
        alu_rd = alu_rs + alu_rt;
        alu_of = (alu_rs[31] == alu_rt[31]) && (alu_rd[31] != alu_rs[31]);
      end
      default: alu_rd = alu_rs;
    endcase
    alu_zf = (alu_rd == 32'h0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt);
    req_op[4*i +: 4]   = op;
    req_rs[32*i +: 32] = rs;
    req_rt[32*i +: 32] = rt;
    req_sa[5*i +: 5]   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_op = '0; req_rs = '0; req_rt = '0; req_sa = '0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id",    64'(rsp_id),    64'h0);
    chk("rst_rsp_rd",    64'(rsp_rd),    64'h0);
    chk("rst_of_count",  64'(of_count),  64'h0);
    req_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;

    // Single requester ADDU 5+7
    set_req(0, 4'd3, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    chk("t2_req_ready", 64'(req_ready), 64'h1);
    chk("t2_alu_op",    64'(alu_op),    64'h3);
    tick();
    req_valid = 2'b00;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_id",    64'(rsp_id),    64'h0);
    chk("t2_rsp_rd",    64'(rsp_rd),    64'd12);
    chk("t2_rsp_zf",    64'(rsp_zf),    64'h0);

    // Idle drive
    #1;
    chk("idle_alu_op", 64'(alu_op), 64'h0);
    chk("idle_alu_rs", 64'(alu_rs), 64'h0);
    chk("idle_alu_rt", 64'(alu_rt), 64'h0);
    tick();
    chk("drain_rsp_valid", 64'(rsp_valid), 64'h0);

    // Both valid; pointer is 1 after the first accept
    set_req(0, 4'd3, 32'd1, 32'd2);
    set_req(1, 4'd6, 32'd3, 32'd3);
    req_valid = 2'b11;
    #1;
    chk("rr_first_ready", 64'(req_ready), 64'h2);
    tick();
    chk("rr1_id", 64'(rsp_id), 64'h1);
    chk("rr1_rd", 64'(rsp_rd), 64'h0);
    chk("rr1_zf", 64'(rsp_zf), 64'h1);
    chk("rr1_ready", 64'(req_ready), 64'h1);
    tick();
    chk("rr2_id", 64'(rsp_id), 64'h0);
    chk("rr2_rd", 64'(rsp_rd), 64'd3);
    chk("rr2_ready", 64'(req_ready), 64'h2);
    tick();
    chk("rr3_id", 64'(rsp_id), 64'h1);

    // Backpressure for 3 cycles
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready", 64'(req_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_id",    64'(rsp_id),    64'h1);
      chk("bp_rd",    64'(rsp_rd),    64'h0);
      chk("bp_ready_hold", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'h1);
    tick();
    chk("rel_valid", 64'(rsp_valid), 64'h1);
    chk("rel_id",    64'(rsp_id),    64'h0);
    chk("rel_rd",    64'(rsp_rd),    64'd3);

    // Overflow and counter saturation (OFCW=3 -> all-ones = 7)
    set_req(0, 4'd11, 32'h7FFF_FFFF, 32'h1);
    req_valid = 2'b01;
    tick();
    chk("ovf_rsp_of", 64'(rsp_of), 64'h1);
    chk("ovf_rsp_rd", 64'(rsp_rd), 64'h8000_0000);
    chk("ovf_count1", 64'(of_count), 64'd1);
    for (int c = 0; c < 5; c++) tick();
    chk("ovf_count6", 64'(of_count), 64'd6);
    tick();
    chk("ovf_count7", 64'(of_count), 64'd7);
    tick();
    chk("ovf_sat", 64'(of_count), 64'd7);
    chk("ovf_no_bubble", 64'(req_ready), 64'h1);

    // Withdrawn request while stalled produces no response
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    tick();
    set_req(1, 4'd3, 32'd9, 32'd9);
    req_valid = 2'b10;
    #1;
    chk("wd_ready", 64'(req_ready), 64'h0);
    chk("wd_alu_rs", 64'(alu_rs), 64'd9);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    chk("wd_no_rsp", 64'(rsp_valid), 64'h0);
    tick();
    chk("wd_no_rsp2", 64'(rsp_valid), 64'h0);

    // Reset mid-traffic
    set_req(0, 4'd11, 32'h7FFF_FFFF, 32'h1);
    req_valid = 2'b11;
    tick();
    chk("pre_rst_valid", 64'(rsp_valid), 64'h1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_rd",    64'(rsp_rd),    64'h0);
    chk("mid_rst_of",    64'(rsp_of),    64'h0);
    chk("mid_rst_count", 64'(of_count),  64'h0);
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_ptr0", 64'(req_ready), 64'h1);
    tick();
    chk("post_rst_id", 64'(rsp_id), 64'h0);
    chk("post_rst_count", 64'(of_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
